// File: rtl/spi_bridge_pkg.sv
// spi_bridge_pkg: shared opcodes, FSM state type, response tags and
// response-word builders for the SPI command bridge.
package spi_bridge_pkg;

  // Command opcodes carried in cmd[31:30]
  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_READ   = 2'b10;
  localparam logic [1:0] OP_STATUS = 2'b11;

  // Response word tags in bits [31:24]
  localparam logic [7:0] TAG_WR = 8'h57;
  localparam logic [7:0] TAG_ST = 8'h53;

  // Read response when the register bus never acknowledges
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_BUS_WR    = 3'd2,
    ST_BUS_RD    = 3'd3,
    ST_RESP      = 3'd4
  } state_e;

  // Write response: tag, error flag at bit 16, 16-bit address
  function automatic logic [31:0] wr_resp(input logic err, input logic [15:0] addr);
    return {TAG_WR, 7'b0, err, addr};
  endfunction

  // Status response; busy bit is always 1 because the word is built while
  // the FSM is leaving IDLE
  function automatic logic [31:0] status_word(input logic [7:0] drop_cnt,
                                              input logic       sticky_timeout,
                                              input logic       sticky_drop);
    return {TAG_ST, 8'h00, drop_cnt, 5'b0, sticky_timeout, sticky_drop, 1'b1};
  endfunction

endpackage

// File: rtl/spi_bridge_timeout.sv
// spi_bridge_timeout: load-and-count-down watchdog. While load is high the
// counter is preset; while en is high it counts down to zero and holds there.
// done flags an enabled counter that has reached zero.
module spi_bridge_timeout #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: preset on load, otherwise decrement toward zero while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = en && !load && (cnt_q == '0);

endmodule

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: decodes 32-bit SPI command words (NOP/WRITE/READ/STATUS),
// runs one register-bus transaction at a time and returns one response word.
// Optional bus watchdog enabled by defining SPI_BRIDGE_TIMEOUT_EN.
module spi_reg_bridge
  import spi_bridge_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [31:0]       tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [31:0]       reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [31:0]       reg_rdata,
  input  logic              reg_ack,
  output logic              busy
);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] resp_q, resp_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic        sticky_drop_q, sticky_drop_d;
  logic        sticky_to_q, sticky_to_d;

  logic [1:0]  op;
  logic        in_bus;
  logic        rx_drop;
  logic        status_clr;
  logic        timeout_hit;

  assign op      = rx_data[31:30];
  assign in_bus  = (state_q == ST_BUS_WR) || (state_q == ST_BUS_RD);
  assign rx_drop = rx_valid && (in_bus || (state_q == ST_RESP));

`ifdef SPI_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  // Preset outside the bus states so the first bus cycle already sees
  // TIMEOUT-1; the strobe is then high for exactly TIMEOUT cycles.
  spi_bridge_timeout #(
    .CNT_W (CNT_W)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load     (!in_bus),
    .load_val (CNT_W'(TIMEOUT - 1)),
    .en       (in_bus),
    .done     (timeout_hit)
  );
`else
  // Watchdog absent: wait forever for reg_ack. TIMEOUT has no effect, the
  // compare is constant false.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  // Next-state, datapath loads and drop/sticky bookkeeping
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    resp_d        = resp_q;
    drop_cnt_d    = drop_cnt_q;
    sticky_drop_d = sticky_drop_q;
    sticky_to_d   = sticky_to_q;
    status_clr    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          case (op)
            OP_WRITE: begin
              addr_d  = rx_data[15:0];
              state_d = ST_WAIT_DATA;
            end
            OP_READ: begin
              addr_d  = rx_data[15:0];
              state_d = ST_BUS_RD;
            end
            OP_STATUS: begin
              resp_d     = status_word(drop_cnt_q, sticky_to_q, sticky_drop_q);
              status_clr = 1'b1;
              state_d    = ST_RESP;
            end
            default: ; // NOP: no response, stay idle
          endcase
        end
      end

      ST_WAIT_DATA: begin
        if (rx_valid) begin
          wdata_d = rx_data;
          state_d = ST_BUS_WR;
        end
      end

      ST_BUS_WR: begin
        // An ack coinciding with the watchdog expiry still counts as success
        if (reg_ack) begin
          resp_d  = wr_resp(1'b0, addr_q);
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          resp_d      = wr_resp(1'b1, addr_q);
          sticky_to_d = 1'b1;
          state_d     = ST_RESP;
        end
      end

      ST_BUS_RD: begin
        if (reg_ack) begin
          resp_d  = reg_rdata;
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          resp_d      = TIMEOUT_DATA;
          sticky_to_d = 1'b1;
          state_d     = ST_RESP;
        end
      end

      ST_RESP: begin
        if (tx_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A STATUS read clears the counters first; a coincident drop then counts once
    if (status_clr) begin
      sticky_to_d   = 1'b0;
      sticky_drop_d = rx_drop;
      drop_cnt_d    = rx_drop ? 8'd1 : 8'd0;
    end else if (rx_drop) begin
      sticky_drop_d = 1'b1;
      if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  // State and datapath registers; reset drops any bus strobe immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      resp_q        <= '0;
      drop_cnt_q    <= '0;
      sticky_drop_q <= 1'b0;
      sticky_to_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      resp_q        <= resp_d;
      drop_cnt_q    <= drop_cnt_d;
      sticky_drop_q <= sticky_drop_d;
      sticky_to_q   <= sticky_to_d;
    end
  end

  // Outputs decode directly from the registered state, so address and write
  // data are stable for the whole time a strobe is high
  assign rx_ready  = (state_q == ST_IDLE) || (state_q == ST_WAIT_DATA);
  assign reg_wr    = (state_q == ST_BUS_WR);
  assign reg_rd    = (state_q == ST_BUS_RD);
  assign tx_valid  = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);
  assign reg_addr  = addr_q[ADDR_W-1:0];
  assign reg_wdata = wdata_q;
  assign tx_data   = resp_q;

endmodule
